data_assembly_register: RTL and testbench
=========================================

// Module: data_assembly_register
// PURPOSE
//  Parametrised successor of the 32-bit byte-load data register. Assembles a DATA_WIDTH
//  word from IN_WIDTH-bit lanes with sign/zero load, shift-in either direction, shift-out
//  and clear. Tracks lane fill and presents the completed word over a valid/ready handshake
//  to the downstream register file / ALU path.
// PARAMETERS
//  DATA_WIDTH  32  width of DROut; must be an integer multiple of IN_WIDTH
//  IN_WIDTH     8  width of input lane I; LANES = DATA_WIDTH/IN_WIDTH (localparam, >=2)
// PORTS
//  Clock     in   1              rising-edge clock
//  Reset     in   1              asynchronous, active-low reset
//  E         in   1              operation enable; FunSel ignored when 0
//  FunSel    in   3              operation select (see BEHAVIOUR)
//  I         in   IN_WIDTH       input lane
//  OutReady  in   1              downstream accepts word when OutValid=1
//  DROut     out  DATA_WIDTH     register contents
//  Count     out  $clog2(LANES+1) lanes currently loaded, 0..LANES
//  OutValid  out  1              word complete (Count==LANES)
//  Ovf       out  1              sticky overflow flag (only with DATA_ASSY_OVF_EN)
// BEHAVIOUR
//  - Reset (async, Reset=0): DROut=0, Count=0, OutValid=0, Ovf=0; mid-operation reset
//    discards partial word immediately, no handshake completes.
//  - All state updates on rising Clock; outputs are registered, 1-cycle latency.
//  - State by Count: EMPTY (0), PARTIAL (1..LANES-1), FULL (LANES). OutValid=1 iff FULL.
//  - Handshake: accept = OutValid & OutReady. On accept, Count->0 (DROut retained),
//    evaluated BEFORE any E operation in the same cycle.
//  - FunSel (E=1), with c = Count after accept:
//    000 sign load : DROut={sext(I)}, Count=1
//    001 zero load : DROut={0,I}, Count=1
//    010 shl in    : DROut={DROut[DW-IW-1:0],I}, Count=min(c+1,LANES)
//    011 shr in    : DROut={I,DROut[DW-1:IW]}, Count=min(c+1,LANES)
//    100 clear     : DROut=0, Count=0, Ovf=0
//    101 shl out   : DROut=DROut<<IW (zero fill), Count=max(c-1,0)
//    110 shr out   : DROut=DROut>>IW logical, Count=max(c-1,0)
//    111 asr out   : DROut=DROut>>>IW (sign fill), Count=max(c-1,0)
//  - Shift-in while FULL without accept: shift occurs, oldest lane lost, Count stays LANES.
//  - Shift-out from EMPTY: DROut still shifts, Count stays 0.
//  - E=0: DROut and Count hold; accept still clears Count.
//  - Count never exceeds LANES nor wraps below 0.
// CONFIGURATION
//  DATA_ASSY_OVF_EN defined: Ovf port present; set sticky on any shift-in (010/011) while
//    FULL and no accept that cycle; cleared only by FunSel=100 or Reset.
//  Not defined: Ovf port and logic absent; overflow silently overwrites as above.
// TESTING (defaults DATA_WIDTH=32, IN_WIDTH=8)
//  Reset=0 mid-fill (Count=2) -> DROut=0, Count=0, OutValid=0 without waiting for Clock.
//  E=1 FunSel=000 I=8'h80 -> DROut=32'hFFFFFF80, Count=1; FunSel=001 I=8'h80 -> 32'h00000080.
//  FunSel=100 then 010 with I=11,22,33,44 -> DROut=32'h11223344, Count=4, OutValid=1
//    after 4th edge; OutReady=1 E=0 -> Count=0, OutValid=0, DROut unchanged.
//  FULL 32'h11223344, OutReady=1, E=1 FunSel=010 I=8'h55 -> DROut=32'h22334455, Count=1.
//  FULL, OutReady=0, FunSel=011 I=8'h66 -> DROut=32'h66112233, Count=4, Ovf=1 (macro);
//    FunSel=100 -> Ovf=0, DROut=0.
//  DROut=32'h80000000 Count=4, FunSel=111 -> 32'hFF800000, Count=3; 110 -> 32'h00FF8000, Count=2.

Source files
------------

// File: rtl/data_assembly_register.sv
// Lane-wise data assembly register: builds a DATA_WIDTH word from IN_WIDTH lanes, hands it off via valid/ready.
// Optional sticky overflow flag and Ovf port when DATA_ASSY_OVF_EN is defined.
module data_assembly_register #(
   parameter int DATA_WIDTH = 32,
   parameter int IN_WIDTH   = 8
) (
   input  logic                                         Clock,
   input  logic                                         Reset,
   input  logic                                         E,
   input  logic [2:0]                                   FunSel,
   input  logic [IN_WIDTH-1:0]                          I,
   input  logic                                         OutReady,
   output logic [DATA_WIDTH-1:0]                        DROut,
   output logic [$clog2(DATA_WIDTH/IN_WIDTH+1)-1:0]     Count,
   output logic                                         OutValid
`ifdef DATA_ASSY_OVF_EN
   ,
   output logic                                         Ovf
`endif
);

   localparam int LANES = DATA_WIDTH / IN_WIDTH;
   localparam int CW    = $clog2(LANES + 1);
   localparam logic [CW-1:0] FULL_C = CW'(LANES);

   typedef enum logic [2:0] {
      OP_SLOAD = 3'b000,
      OP_ZLOAD = 3'b001,
      OP_SHLI  = 3'b010,
      OP_SHRI  = 3'b011,
      OP_CLR   = 3'b100,
      OP_SHLO  = 3'b101,
      OP_SHRO  = 3'b110,
      OP_ASRO  = 3'b111
   } op_t;

   // Lane count saturates at both ends instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == FULL_C) ? c : c + CW'(1);
   endfunction

   function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
      return (c == '0) ? c : c - CW'(1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] v);
      return {{(DATA_WIDTH-IN_WIDTH){v[IN_WIDTH-1]}}, v};
   endfunction

   logic [DATA_WIDTH-1:0]        dr_p0, dr_nxt;
   logic signed [DATA_WIDTH-1:0] dr_s;
   logic [CW-1:0]                cnt_p0, cnt_nxt, cnt_acc;
   logic                         vld_p0;
   logic                         accept;
   logic                         ovf_p0, ovf_nxt;
   op_t                          op;

   assign accept = vld_p0 & OutReady;
   // Handshake is resolved first; the operation then sees the post-accept count.
   assign cnt_acc = accept ? '0 : cnt_p0;
   assign dr_s    = dr_p0;
   assign op      = op_t'(FunSel);

   always_comb begin
      dr_nxt  = dr_p0;
      cnt_nxt = cnt_acc;
      ovf_nxt = ovf_p0;
      if (E) begin
         case (op)
            OP_SLOAD: begin dr_nxt = sext(I);                          cnt_nxt = CW'(1); end
            OP_ZLOAD: begin dr_nxt = {{(DATA_WIDTH-IN_WIDTH){1'b0}}, I}; cnt_nxt = CW'(1); end
            OP_SHLI: begin
               dr_nxt  = {dr_p0[DATA_WIDTH-IN_WIDTH-1:0], I};
               cnt_nxt = sat_inc(cnt_acc);
               if (cnt_acc == FULL_C) ovf_nxt = 1'b1;
            end
            OP_SHRI: begin
               dr_nxt  = {I, dr_p0[DATA_WIDTH-1:IN_WIDTH]};
               cnt_nxt = sat_inc(cnt_acc);
               if (cnt_acc == FULL_C) ovf_nxt = 1'b1;
            end
            OP_CLR: begin dr_nxt = '0; cnt_nxt = '0; ovf_nxt = 1'b0; end
            OP_SHLO: begin dr_nxt = dr_p0 << IN_WIDTH;             cnt_nxt = sat_dec(cnt_acc); end
            OP_SHRO: begin dr_nxt = dr_p0 >> IN_WIDTH;             cnt_nxt = sat_dec(cnt_acc); end
            OP_ASRO: begin dr_nxt = $unsigned(dr_s >>> IN_WIDTH);  cnt_nxt = sat_dec(cnt_acc); end
            default: ;
         endcase
      end
   end

   // Stage p0: registered word, lane count, valid and overflow.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         dr_p0  <= '0;
         cnt_p0 <= '0;
         vld_p0 <= 1'b0;
         ovf_p0 <= 1'b0;
      end else begin
         dr_p0  <= dr_nxt;
         cnt_p0 <= cnt_nxt;
         vld_p0 <= (cnt_nxt == FULL_C);
         ovf_p0 <= ovf_nxt;
      end
   end

   assign DROut    = dr_p0;
   assign Count    = cnt_p0;
   assign OutValid = vld_p0;
`ifdef DATA_ASSY_OVF_EN
   assign Ovf = ovf_p0;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_p0;
`endif

endmodule

// File: tb/tb_data_assembly_register.sv
// Directed bench for data_assembly_register at DATA_WIDTH=32, IN_WIDTH=8.
module tb_data_assembly_register;

   logic        Clock;
   logic        Reset;
   logic        E;
   logic [2:0]  FunSel;
   logic [7:0]  I;
   logic        OutReady;
   logic [31:0] DROut;
   logic [2:0]  Count;
   logic        OutValid;
`ifdef DATA_ASSY_OVF_EN
   logic        Ovf;
`endif

   int nvec  = 0;
   int nfail = 0;

   data_assembly_register #(.DATA_WIDTH(32), .IN_WIDTH(8)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .E        (E),
      .FunSel   (FunSel),
      .I        (I),
      .OutReady (OutReady),
      .DROut    (DROut),
      .Count    (Count),
      .OutValid (OutValid)
`ifdef DATA_ASSY_OVF_EN
      ,
      .Ovf      (Ovf)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic op(input logic [2:0] fs, input logic [7:0] din);
      E = 1'b1; FunSel = fs; I = din;
      tick();
   endtask

   task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      op(3'b100, 8'h00);
      op(3'b010, a);
      op(3'b010, b);
      op(3'b010, c);
      op(3'b010, d);
   endtask

   initial begin
      Reset = 1'b0; E = 1'b0; FunSel = 3'b000; I = 8'h00; OutReady = 1'b0;
      repeat (2) tick();
      check("rst_drout", DROut, 32'h0);
      check("rst_count", {29'b0, Count}, 32'd0);
      check("rst_valid", {31'b0, OutValid}, 32'd0);
      Reset = 1'b1;
      tick();

      op(3'b000, 8'h80);
      check("sload_drout", DROut, 32'hFFFFFF80);
      check("sload_count", {29'b0, Count}, 32'd1);
      op(3'b001, 8'h80);
      check("zload_drout", DROut, 32'h00000080);
      check("zload_count", {29'b0, Count}, 32'd1);

      // async reset in the middle of a fill
      op(3'b100, 8'h00);
      op(3'b010, 8'h11);
      op(3'b010, 8'h22);
      check("mid_count", {29'b0, Count}, 32'd2);
      E = 1'b0;
      Reset = 1'b0;
      #1;
      check("async_drout", DROut, 32'h0);
      check("async_count", {29'b0, Count}, 32'd0);
      check("async_valid", {31'b0, OutValid}, 32'd0);
      Reset = 1'b1;
      tick();

      op(3'b100, 8'h00);
      op(3'b010, 8'h11);
      op(3'b010, 8'h22);
      op(3'b010, 8'h33);
      check("fill3_count", {29'b0, Count}, 32'd3);
      check("fill3_valid", {31'b0, OutValid}, 32'd0);
      op(3'b010, 8'h44);
      check("fill4_drout", DROut, 32'h11223344);
      check("fill4_count", {29'b0, Count}, 32'd4);
      check("fill4_valid", {31'b0, OutValid}, 32'd1);

      E = 1'b0; OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      check("acc_count", {29'b0, Count}, 32'd0);
      check("acc_valid", {31'b0, OutValid}, 32'd0);
      check("acc_drout", DROut, 32'h11223344);
      tick();
      check("hold_drout", DROut, 32'h11223344);

      fill(8'h11, 8'h22, 8'h33, 8'h44);
      OutReady = 1'b1;
      op(3'b010, 8'h55);
      OutReady = 1'b0;
      check("accshl_drout", DROut, 32'h22334455);
      check("accshl_count", {29'b0, Count}, 32'd1);
      check("accshl_valid", {31'b0, OutValid}, 32'd0);

      fill(8'h11, 8'h22, 8'h33, 8'h44);
      op(3'b011, 8'h66);
      check("ovf_drout", DROut, 32'h66112233);
      check("ovf_count", {29'b0, Count}, 32'd4);
      check("ovf_valid", {31'b0, OutValid}, 32'd1);
`ifdef DATA_ASSY_OVF_EN
      check("ovf_flag", {31'b0, Ovf}, 32'd1);
      E = 1'b0;
      tick();
      check("ovf_sticky", {31'b0, Ovf}, 32'd1);
`endif
      op(3'b100, 8'h00);
      check("clr_drout", DROut, 32'h0);
      check("clr_count", {29'b0, Count}, 32'd0);
`ifdef DATA_ASSY_OVF_EN
      check("clr_ovf", {31'b0, Ovf}, 32'd0);
`endif

      fill(8'h80, 8'h00, 8'h00, 8'h00);
      check("msb_drout", DROut, 32'h80000000);
      op(3'b111, 8'h00);
      check("asr_drout", DROut, 32'hFF800000);
      check("asr_count", {29'b0, Count}, 32'd3);
      op(3'b110, 8'h00);
      check("shr_drout", DROut, 32'h00FF8000);
      check("shr_count", {29'b0, Count}, 32'd2);
      op(3'b101, 8'h00);
      check("shl_drout", DROut, 32'hFF800000);
      check("shl_count", {29'b0, Count}, 32'd1);
      op(3'b110, 8'h00);
      check("shr0_count", {29'b0, Count}, 32'd0);
      op(3'b110, 8'h00);
      check("empty_drout", DROut, 32'h0000FF80);
      check("empty_count", {29'b0, Count}, 32'd0);

      // accept and shift-out in one cycle: count from 0 stays 0
      fill(8'hA1, 8'hB2, 8'hC3, 8'hD4);
      OutReady = 1'b1;
      op(3'b110, 8'h00);
      OutReady = 1'b0;
      check("accso_drout", DROut, 32'h00A1B2C3);
      check("accso_count", {29'b0, Count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
